pipe_stage_register: RTL and testbench

- Generic parametrised pipeline-stage register. It is the successor to the fixed-width, stall-only stage registers.
- Carries one DATA_WIDTH-bit payload per cycle between two CPU pipeline stages, using a valid/ready handshake.
- Supports a global BUSYWAIT stall and a synchronous FLUSH that inserts a bubble.
- An optional skid entry lets READY_OUT be driven from a flop, which breaks the combinational ready path back to IF.
- Intended for instantiation as IF/ID, ID/EX, EX/MEM and MEM/WB with per-stage widths.

---
 rtl/pipe_stage_register.sv | 133 +++++++++++++
 tb/tb_pipe_stage_register.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_register.sv
// Valid/ready pipeline-stage register with optional skid entry, flush and stall counter.
// Latency 1 cycle; BUSYWAIT or !READY_IN holds the output, and with SKID_EN=1 one extra payload is absorbed before READY_OUT drops.
module pipe_stage_register #(
    parameter int                    DATA_WIDTH   = 96,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = {DATA_WIDTH{1'b0}},
    parameter bit                    SKID_EN      = 1'b1,
    parameter int                    CNT_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  VALID_IN,
    output logic                  READY_OUT,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  VALID_OUT,
    input  logic                  READY_IN,
    input  logic                  BUSYWAIT,
    input  logic                  FLUSH,
    output logic [1:0]            OCCUPANCY,
    output logic [CNT_WIDTH-1:0]  STALL_COUNT
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic                  rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0] skid_val;
    logic                  skid_load, skid_clear;
    logic                  valid_out, ready_out, accept, consume;

    assign valid_out = (state_q != ST_EMPTY);
    assign consume   = valid_out & READY_IN & ~BUSYWAIT;
    assign accept    = VALID_IN & ready_out;

    // rdy_q is low only in reset and in SKID; with SKID_EN=0 it acts purely as an out-of-reset gate.
    generate
        if (SKID_EN) begin : g_skid
            logic [DATA_WIDTH-1:0] skid_q, skid_d;

            always_comb begin
                skid_d = skid_q;
                if (skid_clear)
                    skid_d = BUBBLE_VALUE;
                else if (skid_load)
                    skid_d = DATA_IN;
            end

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET)
                    skid_q <= BUBBLE_VALUE;
                else
                    skid_q <= skid_d;
            end

            assign skid_val  = skid_q;
            assign ready_out = rdy_q;
        end else begin : g_noskid
            assign skid_val  = BUBBLE_VALUE;
            assign ready_out = rdy_q & (~valid_out | (READY_IN & ~BUSYWAIT));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (FLUSH) begin
            state_d    = ST_EMPTY;
            data_d     = BUBBLE_VALUE;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        data_d  = DATA_IN;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        data_d = DATA_IN;
                    end else if (accept && SKID_EN) begin
                        state_d   = ST_SKID;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (consume) begin
                        state_d = ST_FULL;
                        data_d  = skid_val;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        rdy_d   = (state_d != ST_SKID);
        stall_d = stall_q;
        if (valid_out && !consume && !FLUSH && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_EMPTY;
            data_q  <= BUBBLE_VALUE;
            stall_q <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            stall_q <= stall_d;
            rdy_q   <= rdy_d;
        end
    end

    // State encoding doubles as the entry count.
    assign OCCUPANCY   = state_q;
    assign VALID_OUT   = valid_out;
    assign READY_OUT   = ready_out;
    assign DATA_OUT    = data_q;
    assign STALL_COUNT = stall_q;

endmodule

// File: tb/tb_pipe_stage_register.sv
// Bench for pipe_stage_register: a skid instance (4-bit counter) and a no-skid instance share one stimulus stream,
// each compared against a queue-based reference model.
module tb_pipe_stage_register;

    localparam logic [31:0] BUB_A = 32'h0000_0000;
    localparam logic [31:0] BUB_B = 32'hDEAD_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] din;
    logic        vin, rin, bw, fl;

    logic        a_rdy, a_vld, b_rdy, b_vld;
    logic [31:0] a_dat, b_dat;
    logic [1:0]  a_occ, b_occ;
    logic [3:0]  a_cnt;
    logic [15:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] douta_m, doutb_m;
    logic        rdya_m;
    logic        en_m;
    int          cnta_m, cntb_m;

    pipe_stage_register #(.DATA_WIDTH(32), .BUBBLE_VALUE(BUB_A), .SKID_EN(1'b1), .CNT_WIDTH(4)) u_a (
        .CLK(clk), .RESET(rst_n), .DATA_IN(din), .VALID_IN(vin), .READY_OUT(a_rdy),
        .DATA_OUT(a_dat), .VALID_OUT(a_vld), .READY_IN(rin), .BUSYWAIT(bw), .FLUSH(fl),
        .OCCUPANCY(a_occ), .STALL_COUNT(a_cnt)
    );

    pipe_stage_register #(.DATA_WIDTH(32), .BUBBLE_VALUE(BUB_B), .SKID_EN(1'b0), .CNT_WIDTH(16)) u_b (
        .CLK(clk), .RESET(rst_n), .DATA_IN(din), .VALID_IN(vin), .READY_OUT(b_rdy),
        .DATA_OUT(b_dat), .VALID_OUT(b_vld), .READY_IN(rin), .BUSYWAIT(bw), .FLUSH(fl),
        .OCCUPANCY(b_occ), .STALL_COUNT(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rdyb_m();
        return en_m && (qb.size() == 0 || (rin && !bw));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a_rdy"}, 32'(a_rdy), 32'(rdya_m));
        chk({tag, ".a_vld"}, 32'(a_vld), 32'(qa.size() > 0));
        chk({tag, ".a_dat"}, a_dat, douta_m);
        chk({tag, ".a_occ"}, 32'(a_occ), 32'(qa.size()));
        chk({tag, ".a_cnt"}, 32'(a_cnt), 32'(cnta_m));
        chk({tag, ".b_rdy"}, 32'(b_rdy), 32'(rdyb_m()));
        chk({tag, ".b_vld"}, 32'(b_vld), 32'(qb.size() > 0));
        chk({tag, ".b_dat"}, b_dat, doutb_m);
        chk({tag, ".b_occ"}, 32'(b_occ), 32'(qb.size()));
        chk({tag, ".b_cnt"}, 32'(b_cnt), 32'(cntb_m));
    endtask

    // Drive one cycle of inputs, check combinational view, advance model and DUT by one edge, check again.
    task automatic step(input string tag, input logic v, input logic [31:0] d,
                        input logic r, input logic b, input logic f);
        logic acc_a, con_a, acc_b, con_b;
        vin = v; din = d; rin = r; bw = b; fl = f;
        #1;
        check_all({tag, ".pre"});
        acc_a = v && rdya_m;
        con_a = (qa.size() > 0) && r && !b;
        acc_b = v && rdyb_m();
        con_b = (qb.size() > 0) && r && !b;
        if (qa.size() > 0 && !con_a && !f && cnta_m < 15)    cnta_m++;
        if (qb.size() > 0 && !con_b && !f && cntb_m < 65535) cntb_m++;
        if (f) begin
            qa.delete(); qb.delete();
            douta_m = BUB_A; doutb_m = BUB_B;
        end else begin
            if (con_a) void'(qa.pop_front());
            if (acc_a) qa.push_back(d);
            if (con_b) void'(qb.pop_front());
            if (acc_b) qb.push_back(d);
            if (qa.size() > 0) douta_m = qa[0];
            if (qb.size() > 0) doutb_m = qb[0];
        end
        rdya_m = (qa.size() < 2);
        en_m   = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ".post"});
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        douta_m = BUB_A; doutb_m = BUB_B;
        rdya_m = 1'b0; en_m = 1'b0;
        cnta_m = 0; cntb_m = 0;
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released mid-cycle.
    task automatic reset_pulse(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all({tag, ".asserted"});
        @(posedge clk);
        #1 check_all({tag, ".held"});
        rst_n = 1'b1;
        #1 check_all({tag, ".released"});
    endtask

    initial begin
        vin = 1'b0; din = '0; rin = 1'b0; bw = 1'b0; fl = 1'b0;
        rst_n = 1'b1;
        model_reset();
        reset_pulse("por");
        step("idle_after_rst", 0, 32'h0, 0, 0, 0);

        // streaming at one payload per cycle
        step("stream0", 1, 32'h0050_0093, 1, 0, 0);
        step("stream1", 1, 32'h00a0_0113, 1, 0, 0);
        step("stream_end", 0, 32'h0, 1, 0, 0);

        // reset while FULL discards the payload
        step("fill", 1, 32'h1111_2222, 0, 0, 0);
        reset_pulse("mid_reset");
        step("after_mid_reset", 0, 32'h0, 1, 0, 0);

        // skid absorbs P1 under BUSYWAIT, then drains in order
        step("skid_p0", 1, 32'hAAAA_0001, 1, 0, 0);
        step("skid_p1", 1, 32'hAAAA_0002, 1, 1, 0);
        chk("skid_occ2", 32'(a_occ), 32'd2);
        chk("skid_rdy0", 32'(a_rdy), 32'd0);
        chk("skid_hold_p0", a_dat, 32'hAAAA_0001);
        step("skid_drain1", 0, 32'h0, 1, 0, 0);
        chk("skid_p1_out", a_dat, 32'hAAAA_0002);
        step("skid_drain2", 0, 32'h0, 1, 0, 0);
        chk("skid_empty_rdy", 32'(a_rdy), 32'd1);

        // flush from SKID with a same-edge offer
        step("fl_fill0", 1, 32'hBBBB_0001, 0, 0, 0);
        step("fl_fill1", 1, 32'hBBBB_0002, 0, 0, 0);
        step("flush", 1, 32'hBBBB_0003, 0, 0, 1);
        chk("flush_bubble", a_dat, BUB_A);
        step("after_flush", 0, 32'h0, 1, 0, 0);
        step("after_flush2", 0, 32'h0, 1, 0, 0);

        // stall counter saturation (4-bit on instance A)
        step("sat_fill", 1, 32'hCCCC_0001, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("sat_hold", 0, 32'h0, 0, 0, 0);
        chk("sat_15", 32'(a_cnt), 32'd15);
        step("sat_stay", 0, 32'h0, 0, 0, 0);
        chk("sat_stay_15", 32'(a_cnt), 32'd15);

        // no-skid instance: ready follows downstream combinationally while FULL
        rin = 1'b1; bw = 1'b0; #1;
        chk("b_rdy_comb_hi", 32'(b_rdy), 32'd1);
        bw = 1'b1; #1;
        chk("b_rdy_comb_lo", 32'(b_rdy), 32'd0);
        step("b_bw_offer", 1, 32'hDDDD_0001, 1, 1, 0);
        chk("b_occ_le1", 32'(b_occ <= 2'd1), 32'd1);
        step("flush2", 0, 32'h0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse("rnd_reset");
            end else begin
                step("rnd", 1'($urandom_range(0, 99) < 65), $urandom,
                     1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 25),
                     1'($urandom_range(0, 99) < 4));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
